// File: rtl/adc_spi_responder.sv
// adc_spi_responder: MCP3008-style SPI ADC responder, serial bus oversampled in the clk domain.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ad_clk,
  input  logic        cs,
  input  logic        din,
  input  logic [79:0] ch_data,
  output logic        dout,
  output logic        dout_oe,
  output logic        conv_valid,
  output logic [2:0]  conv_ch,
  output logic        conv_sgl
);
  typedef enum logic [2:0] {IDLE, WAIT_START, CONFIG, NULL_BIT, DATA, TAIL} state_t;
  state_t state;
  logic [SYNC_STAGES-1:0] clk_s, cs_s, din_s;
  logic ad_rise, ad_fall, cs_rise, cs_fall, d;
  logic [2:0] cfg, sel_p, sel_n;
  logic [3:0] cnt;
  logic [9:0] shreg, in_p, in_n, value;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      clk_s <= '0;
      cs_s  <= '0;
      din_s <= '0;
    end else begin
      clk_s <= {clk_s[SYNC_STAGES-2:0], ad_clk};
      cs_s  <= {cs_s[SYNC_STAGES-2:0], cs};
      din_s <= {din_s[SYNC_STAGES-2:0], din};
    end
  assign ad_rise = clk_s[SYNC_STAGES-2] & ~clk_s[SYNC_STAGES-1];
  assign ad_fall = ~clk_s[SYNC_STAGES-2] & clk_s[SYNC_STAGES-1];
  assign cs_rise = cs_s[SYNC_STAGES-2] & ~cs_s[SYNC_STAGES-1];
  assign cs_fall = ~cs_s[SYNC_STAGES-2] & cs_s[SYNC_STAGES-1];
  // din taken one stage later than the edge: it has been stable well before the ad_clk rise
  assign d = din_s[SYNC_STAGES-1];
  assign sel_p = {cfg[1:0], d};
  assign sel_n = {cfg[1:0], ~d};
  assign in_p = ch_data[10*sel_p +: 10];
  assign in_n = ch_data[10*sel_n +: 10];
  assign value = cfg[2] ? in_p : (in_p >= in_n ? in_p - in_n : 10'd0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      dout       <= 1'b0;
      dout_oe    <= 1'b0;
      conv_valid <= 1'b0;
      conv_ch    <= 3'd0;
      conv_sgl   <= 1'b0;
      shreg      <= 10'd0;
      cfg        <= 3'd0;
      cnt        <= 4'd0;
    end else begin
      conv_valid <= 1'b0;
      if (cs_rise) begin
        state   <= IDLE;
        dout    <= 1'b0;
        dout_oe <= 1'b0;
      end else if (cs_fall) begin
        state   <= WAIT_START;
        dout    <= 1'b0;
        dout_oe <= 1'b1;
      end else begin
        case (state)
          WAIT_START: if (ad_rise && d) begin
            state <= CONFIG;
            cnt   <= 4'd0;
          end
          CONFIG: if (ad_rise) begin
            cfg <= {cfg[1:0], d};
            cnt <= cnt + 4'd1;
            if (cnt == 4'd3) begin
              shreg      <= value;
              conv_valid <= 1'b1;
              conv_ch    <= sel_p;
              conv_sgl   <= cfg[2];
              state      <= NULL_BIT;
            end
          end
          NULL_BIT: if (ad_fall) begin
            dout  <= 1'b0;
            cnt   <= 4'd0;
            state <= DATA;
          end
          DATA: if (ad_fall) begin
            dout  <= shreg[9];
            shreg <= {shreg[8:0], 1'b0};
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd9) state <= TAIL;
          end
          TAIL: if (ad_fall) dout <= 1'b0;
          default: ;
        endcase
      end
    end
endmodule
